enc_8_3_seq: RTL

- Sequential 8-to-3 priority encoder: the return path for the 3-to-8 decoder.
- Captures an 8-bit request vector when a 74x138-style enable triple is active.
- Emits the index of every set bit, one per valid/ready handshake, highest priority first.
- Used wherever a one-hot or multi-hot select bus must be turned back into binary indices.

---
 rtl/enc_8_3_seq_if.sv | 28 ++
 rtl/enc_8_3_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/enc_8_3_seq_if.sv
// Request/index bus for the sequential 8-to-3 priority encoder.
// The requester drives the load side and ready; the encoder drives the index side.
interface enc_8_3_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
);
  logic [2:0]       en_i;
  logic [WIDTH-1:0] data_i;
  logic             load_i;
  logic             ready_i;
  logic [IDX_W-1:0] data_o;
  logic             valid_o;
  logic             last_o;
  logic [IDX_W:0]   count_o;
  logic             gs_o;
  logic             zero_o;
  logic             busy_o;

  modport master (
    output en_i, data_i, load_i, ready_i,
    input  data_o, valid_o, last_o, count_o, gs_o, zero_o, busy_o
  );

  modport slave (
    input  en_i, data_i, load_i, ready_i,
    output data_o, valid_o, last_o, count_o, gs_o, zero_o, busy_o
  );
endinterface

// File: rtl/enc_8_3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request vector under a
// 74x138-style enable and emits one index per valid/ready handshake.
module enc_8_3_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_W     = 3,
  parameter logic [2:0]  EN_ACTIVE = 3'b100,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  enc_8_3_seq_if.slave       bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_drop;
  logic [IDX_W-1:0] data_q;
  logic             valid_q;
  logic [IDX_W:0]   count_q;
  logic             gs_q;
  logic             zero_q;

  // Later matching bits overwrite earlier ones, so scan order sets priority.
  function automatic logic [IDX_W-1:0] prio(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) idx = IDX_W'(i);
      end else begin
        if (v[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  always_comb begin
    pend_drop         = pend;
    pend_drop[data_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      gs_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_i && (bus.en_i == EN_ACTIVE)) begin
            if (|bus.data_i) begin
              pend    <= bus.data_i;
              data_q  <= prio(bus.data_i);
              count_q <= popcount(bus.data_i);
              valid_q <= 1'b1;
              gs_q    <= 1'b1;
              state   <= EMIT;
            end else begin
              gs_q   <= 1'b0;
              zero_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          // valid_q is always high here, so ready alone completes a handshake.
          if (bus.ready_i) begin
            pend    <= pend_drop;
            count_q <= count_q - (IDX_W+1)'(1);
            if (|pend_drop) begin
              data_q <= prio(pend_drop);
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = valid_q && (count_q == (IDX_W+1)'(1));
  assign bus.count_o = count_q;
  assign bus.gs_o    = gs_q;
  assign bus.zero_o  = zero_q;
  assign bus.busy_o  = (state == EMIT);

endmodule
